// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx                                                        |
// | Purpose  : 16x-oversampled UART receiver. It synchronises rx, finds the   |
// |            start edge, samples each bit at mid-period and holds the       |
// |            received word until the consumer reads it. It flags frame and  |
// |            overrun errors.                                                |
// | Option   : define UART_RX_PARITY_EN to insert an even-parity bit between  |
// |            the data and the stop bit. Without it, parity_err is tied 0.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            tick,
  input  logic            rx,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            valid,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int            NW     = $clog2(DBIT + 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [4:0]    S_MID  = 5'd7;
  localparam logic [4:0]    S_END  = 5'd15;
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [4:0]      s, s_nx;
  logic [NW-1:0]   n, n_nx;
  logic [DBIT-1:0] shift, shift_nx;
  logic            rx_meta, rx_s;
  logic            done_good, done_ferr, done_perr;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_nx;
`endif

  // Two-flop synchroniser for the asynchronous serial line. It resets to the idle level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Register for the FSM state, the tick and bit counters and the shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      s     <= 5'd0;
      n     <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      s     <= s_nx;
      n     <= n_nx;
      shift <= shift_nx;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nx;
`endif
    end
  end

  // Next-state logic. Counters move only on tick, but start detection in IDLE does not wait for tick.
  always_comb begin
    state_nx  = state;
    s_nx      = s;
    n_nx      = n;
    shift_nx  = shift;
    done_good = 1'b0;
    done_ferr = 1'b0;
    done_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx    = par_bit;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          s_nx     = 5'd0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_nx = DATA;
              s_nx     = 5'd0;
              n_nx     = '0;
            end else begin
              // The line went high before mid-start, so this was a glitch.
              state_nx = IDLE;
            end
          end else begin
            s_nx = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_END) begin
            shift_nx = {rx_s, shift[DBIT-1:1]};
            s_nx     = 5'd0;
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              n_nx = n + NW'(1);
            end
          end else begin
            s_nx = s + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == S_END) begin
            par_nx   = rx_s;
            s_nx     = 5'd0;
            state_nx = STOP;
          end else begin
            s_nx = s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            state_nx = IDLE;
            // A framing error wins over a parity error.
            if (!rx_s) begin
              done_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift, par_bit}) begin
              done_perr = 1'b1;
`endif
            end else begin
              done_good = 1'b1;
            end
          end else begin
            s_nx = s + 5'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output register: hold-until-read data, error pulses and the sticky overrun flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err <= done_ferr;
      if (done_good) begin
        // A new word always overwrites dout. It counts as lost only if the old word was unread and not being read now.
        dout  <= shift;
        valid <= 1'b1;
        if (valid && !rd) begin
          overrun_err <= 1'b1;
        end
      end else if (rd && valid) begin
        valid       <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with the frame_err pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= done_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
`default_nettype wire
